// File: rtl/nrst_seq_pkg.sv
// Shared types and width helpers for the sequenced reset release block.
package nrst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SEQ       = 2'd1,
        DONE      = 2'd2
    } state_e;

    function automatic int cnt_width(input int delay);
        return $clog2(delay + 1);
    endfunction

    function automatic int idx_width(input int outs);
        return $clog2(outs + 1);
    endfunction

    function automatic int wdt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/nrst_seq_lock_sync.sv
// Multi-flop bit synchronizer for the asynchronous lock indication.
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK_I,
    input  logic NRST_I,
    input  logic D_I,
    output logic Q_O
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], D_I};
    end

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign Q_O = sync_q[STAGES-1];

endmodule

// File: rtl/nrst_sequencer.sv
// Releases block resets one by one after clock lock; lock loss restarts.
// Optional lock watchdog with sticky ERR_O when NRST_SEQ_WDT_EN is defined.
module nrst_sequencer
    import nrst_seq_pkg::*;
#(
    parameter int NUM_OUTS       = 4,
    parameter int DELAY_CYCLES   = 16,
    parameter int LOCK_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                CLK_I,
    input  logic                NRST_I,
    input  logic                LOCK_I,
    output logic [NUM_OUTS-1:0] NRST_O,
    output logic                DONE_O
`ifdef NRST_SEQ_WDT_EN
    ,
    output logic                ERR_O
`endif
);

    localparam int CW = cnt_width(DELAY_CYCLES);
    localparam int IW = idx_width(NUM_OUTS);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NUM_OUTS-1:0] nrst_q, nrst_d;
    logic                done_q, done_d;
    logic                lock_s;

    lock_sync #(
        .STAGES(LOCK_STAGES)
    ) u_lock_sync (
        .CLK_I (CLK_I),
        .NRST_I(NRST_I),
        .D_I   (LOCK_I),
        .Q_O   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nrst_d  = nrst_q;
        done_d  = done_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                idx_d = '0;
                if (lock_s) begin
                    state_d = SEQ;
                end
            end
            SEQ: begin
                // Lock loss wins over a release due on the same edge.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    nrst_d  = '0;
                    done_d  = 1'b0;
                end else if (cnt_q == CW'(DELAY_CYCLES - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    for (int i = 0; i < NUM_OUTS; i++) begin
                        if (idx_q == IW'(i)) begin
                            nrst_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == IW'(NUM_OUTS - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    nrst_d  = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                idx_d   = '0;
                nrst_d  = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            nrst_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nrst_q  <= nrst_d;
            done_q  <= done_d;
        end
    end

    assign NRST_O = nrst_q;
    assign DONE_O = done_q;

`ifdef NRST_SEQ_WDT_EN
    localparam int WW = wdt_width(TIMEOUT_CYCLES);

    logic [WW-1:0] wdt_q, wdt_d;
    logic          err_q, err_d;

    // Counter saturates at the limit; the error flag is sticky.
    always_comb begin
        wdt_d = '0;
        err_d = err_q;
        if (state_q == WAIT_LOCK) begin
            if (wdt_q == WW'(TIMEOUT_CYCLES - 1)) begin
                err_d = 1'b1;
            end
            if (!lock_s && wdt_q != WW'(TIMEOUT_CYCLES - 1)) begin
                wdt_d = wdt_q + WW'(1);
            end else if (!lock_s) begin
                wdt_d = wdt_q;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            err_q <= err_d;
        end
    end

    assign ERR_O = err_q;
`endif

endmodule
